// File: rtl/pcie_lane_symbol_aligner.sv
// Per-lane receive front end: finds the K28.5 comma in the serial bit stream and frames 10-bit symbols.
// Define ALIGN_ERR_COUNT_EN to build the saturating misaligned-comma counter behind AlignErrors.
module pcie_lane_symbol_aligner #(
  parameter int LOCK_COMMAS   = 4,
  parameter int UNLOCK_COMMAS = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stable,
  input  logic        SerialIn,
  output logic [9:0]  SymbolOut,
  output logic        SymbolValid,
  output logic        Locked,
  output logic [15:0] AlignErrors
);

  localparam logic [9:0] COMMA_RDN = 10'h17C;
  localparam logic [9:0] COMMA_RDP = 10'h283;
  localparam logic [3:0] LOCK_N    = 4'(LOCK_COMMAS);
  localparam logic [3:0] UNLOCK_N  = 4'(UNLOCK_COMMAS);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} alignStateT;

  alignStateT stateQ, stateD;
  logic [9:0] window;
  logic [3:0] phase, phaseD;
  logic [3:0] goodCnt, goodD;
  logic [3:0] badCnt, badD;
  logic [9:0] symbolQ;
  logic       validQ;
  logic       commaMatch, boundary, realign, emit;

  function automatic logic [3:0] satInc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  assign commaMatch = (window == COMMA_RDN) || (window == COMMA_RDP);
  assign boundary   = (phase == 4'd9);

  // Alignment FSM: a realign makes the comma currently in the window a symbol boundary.
  always_comb begin
    stateD  = stateQ;
    goodD   = goodCnt;
    badD    = badCnt;
    realign = 1'b0;
    if (!Stable) begin
      stateD = HUNT;
      goodD  = '0;
      badD   = '0;
    end else begin
      case (stateQ)
        HUNT: begin
          if (commaMatch) begin
            realign = 1'b1;
            goodD   = 4'd1;
            stateD  = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (commaMatch && boundary) begin
            goodD = satInc(goodCnt);
            if (goodD >= LOCK_N) stateD = LOCKED;
          end else if (commaMatch) begin
            realign = 1'b1;
            goodD   = 4'd1;
          end
        end
        LOCKED: begin
          if (commaMatch && boundary) begin
            badD = '0;
          end else if (commaMatch) begin
            badD = satInc(badCnt);
            if (badD >= UNLOCK_N) begin
              realign = 1'b1;
              goodD   = 4'd1;
              badD    = '0;
              stateD  = VERIFY;
            end
          end
        end
        default: stateD = HUNT;
      endcase
    end
    emit = Stable && (stateQ != HUNT) && (boundary || realign);
    if (!Stable || realign || boundary) phaseD = '0;
    else phaseD = phase + 4'd1;
  end

  // The window shifts even while Stable is low so hunting restarts without a refill delay.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ  <= HUNT;
      window  <= '0;
      phase   <= '0;
      goodCnt <= '0;
      badCnt  <= '0;
      symbolQ <= '0;
      validQ  <= 1'b0;
    end else begin
      stateQ  <= stateD;
      window  <= {SerialIn, window[9:1]};
      phase   <= phaseD;
      goodCnt <= goodD;
      badCnt  <= badD;
      validQ  <= emit;
      if (emit) symbolQ <= window;
    end
  end

  assign SymbolOut   = symbolQ;
  assign SymbolValid = validQ;
  assign Locked      = (stateQ == LOCKED);

`ifdef ALIGN_ERR_COUNT_EN
  logic        misComma;
  logic [15:0] alignErrQ;

  assign misComma = Stable && (stateQ == LOCKED) && commaMatch && !boundary;

  // Only Reset clears the error count; losing Stable keeps the history.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) alignErrQ <= '0;
    else if (misComma && (alignErrQ != 16'hFFFF)) alignErrQ <= alignErrQ + 16'd1;
  end

  assign AlignErrors = alignErrQ;
`else
  assign AlignErrors = 16'h0000;
`endif

endmodule

// File: tb/tb_pcie_lane_symbol_aligner.sv
// Scoreboard bench for pcie_lane_symbol_aligner: expected symbols are queued as bits are driven
// and popped whenever the aligner strobes SymbolValid.
module tb_pcie_lane_symbol_aligner;

  localparam logic [9:0] COMMA_N  = 10'h17C;
  localparam logic [9:0] COMMA_P  = 10'h283;
  localparam logic [9:0] DATA_SYM = 10'h2A5;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Stable;
  logic        SerialIn;
  logic [9:0]  SymbolOut;
  logic        SymbolValid;
  logic        Locked;
  logic [15:0] AlignErrors;

  int         checks = 0;
  int         passes = 0;
  int         validCount = 0;
  logic [9:0] expectQ[$];
  logic [9:0] tbWin;
  logic [9:0] monExp;
  int         bitCnt;
  bit         trackEmit;

  pcie_lane_symbol_aligner dut (
    .Clock(Clock),
    .Reset(Reset),
    .Stable(Stable),
    .SerialIn(SerialIn),
    .SymbolOut(SymbolOut),
    .SymbolValid(SymbolValid),
    .Locked(Locked),
    .AlignErrors(AlignErrors)
  );

  always #5 Clock = ~Clock;

  // Every strobed symbol must match the oldest queued expectation.
  always @(negedge Clock) begin
    if (Reset === 1'b0 && SymbolValid === 1'b1) begin
      validCount++;
      checks++;
      if (expectQ.size() == 0) begin
        $display("[TB] FAIL symbol_unexpected: got %h, required no symbol", SymbolOut);
      end else begin
        monExp = expectQ.pop_front();
        if (SymbolOut !== monExp)
          $display("[TB] FAIL symbol_value: got %h, required %h", SymbolOut, monExp);
        else passes++;
      end
    end
  end

  // bitCnt is the phase the aligner should assign to the bit just driven; 9 marks a boundary.
  task automatic sendBit(input logic b);
    SerialIn = b;
    @(posedge Clock);
    #1;
    tbWin  = {b, tbWin[9:1]};
    bitCnt = (bitCnt == 9) ? 0 : bitCnt + 1;
    if (trackEmit && bitCnt == 9) expectQ.push_back(tbWin);
  endtask

  task automatic sendSymbol(input logic [9:0] s);
    for (int i = 0; i < 10; i++) sendBit(s[i]);
  endtask

  task automatic doReset();
    Reset     = 1'b1;
    Stable    = 1'b1;
    SerialIn  = 1'b0;
    expectQ.delete();
    trackEmit = 1'b0;
    bitCnt    = 0;
    tbWin     = '0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  task automatic drain();
    sendBit(1'b0);
    sendBit(1'b0);
    @(negedge Clock);
    #1;
  endtask

  // Three offset bits, then four RD- commas; the first is found in HUNT and never emitted.
  task automatic acquireLock();
    doReset();
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendSymbol(COMMA_N);
    bitCnt    = 9;
    trackEmit = 1'b1;
    repeat (3) sendSymbol(COMMA_N);
  endtask

  task automatic test_reset();
    logic       b;
    logic [9:0] cand;
    bit         sawValid, sawLocked;
    Reset = 1'b1;
    Stable = 1'b0;
    SerialIn = 1'b0;
    @(posedge Clock);
    #2;
    checks += 4;
    if (SymbolOut !== 10'h000) $display("[TB] FAIL reset_symbol: got %h, required 000", SymbolOut); else passes++;
    if (SymbolValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b, required 0", SymbolValid); else passes++;
    if (Locked !== 1'b0) $display("[TB] FAIL reset_locked: got %b, required 0", Locked); else passes++;
    if (AlignErrors !== 16'h0000) $display("[TB] FAIL reset_errors: got %h, required 0000", AlignErrors); else passes++;
    doReset();
    sawValid  = 1'b0;
    sawLocked = 1'b0;
    for (int i = 0; i < 200; i++) begin
      b    = 1'($urandom_range(0, 1));
      cand = {b, tbWin[9:1]};
      if (cand == COMMA_N || cand == COMMA_P) b = ~b;
      sendBit(b);
      if (SymbolValid !== 1'b0) sawValid = 1'b1;
      if (Locked !== 1'b0) sawLocked = 1'b1;
    end
    checks += 2;
    if (sawValid !== 1'b0) $display("[TB] FAIL noise_valid: got %b, required 0", sawValid); else passes++;
    if (sawLocked !== 1'b0) $display("[TB] FAIL noise_locked: got %b, required 0", sawLocked); else passes++;
  endtask

  task automatic test_acquire();
    logic [9:0] sym;
    sym = COMMA_N;
    doReset();
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendSymbol(sym);
    bitCnt    = 9;
    trackEmit = 1'b1;
    sendBit(sym[0]);
    checks += 2;
    if (SymbolValid !== 1'b0) $display("[TB] FAIL hunt_no_emit: got %b, required 0", SymbolValid); else passes++;
    if (Locked !== 1'b0) $display("[TB] FAIL hunt_locked: got %b, required 0", Locked); else passes++;
    for (int i = 1; i < 10; i++) sendBit(sym[i]);
    checks++;
    if (SymbolValid !== 1'b0) $display("[TB] FAIL first_emit_early: got %b, required 0", SymbolValid); else passes++;
    sendBit(sym[0]);
    checks += 2;
    if (SymbolValid !== 1'b1) $display("[TB] FAIL first_emit_valid: got %b, required 1", SymbolValid); else passes++;
    if (SymbolOut !== COMMA_N) $display("[TB] FAIL first_emit_symbol: got %h, required %h", SymbolOut, COMMA_N); else passes++;
    for (int i = 1; i < 10; i++) sendBit(sym[i]);
    sendSymbol(sym);
    checks++;
    if (Locked !== 1'b0) $display("[TB] FAIL lock_early: got %b, required 0", Locked); else passes++;
    sendBit(sym[0]);
    checks++;
    if (Locked !== 1'b1) $display("[TB] FAIL lock_fourth_comma: got %b, required 1", Locked); else passes++;
    for (int i = 1; i < 10; i++) sendBit(sym[i]);
    drain();
    checks++;
    if (expectQ.size() != 0) $display("[TB] FAIL acquire_pending: got %0d, required 0", expectQ.size()); else passes++;
  endtask

  task automatic test_data_stream();
    logic [9:0] pattern [4];
    int         startCount;
    bit         dropped;
    pattern[0] = COMMA_N;
    pattern[1] = DATA_SYM;
    pattern[2] = COMMA_P;
    pattern[3] = DATA_SYM;
    acquireLock();
    startCount = validCount;
    dropped    = 1'b0;
    for (int r = 0; r < 12; r++) begin
      sendSymbol(pattern[r % 4]);
      if (Locked !== 1'b1) dropped = 1'b1;
    end
    drain();
    checks += 3;
    if (dropped !== 1'b0) $display("[TB] FAIL stream_lock_held: got drop=%b, required 0", dropped); else passes++;
    if (validCount - startCount != 13)
      $display("[TB] FAIL stream_pulse_count: got %0d, required 13", validCount - startCount);
    else passes++;
    if (expectQ.size() != 0) $display("[TB] FAIL stream_pending: got %0d, required 0", expectQ.size()); else passes++;
  endtask

  task automatic test_unlock();
    logic [9:0] sym;
    logic [15:0] expErr;
`ifdef ALIGN_ERR_COUNT_EN
    expErr = 16'd3;
`else
    expErr = 16'd0;
`endif
    sym = COMMA_N;
    acquireLock();
    sendSymbol(DATA_SYM);
    sendSymbol(COMMA_P);
    sendBit(1'b0);
    sendSymbol(sym);
    sendSymbol(sym);
    sendSymbol(sym);
    checks++;
    if (Locked !== 1'b1) $display("[TB] FAIL unlock_early: got %b, required 1", Locked); else passes++;
    expectQ.push_back(COMMA_N);
    bitCnt = 9;
    sendBit(sym[0]);
    checks += 4;
    if (Locked !== 1'b0) $display("[TB] FAIL unlock_third: got %b, required 0", Locked); else passes++;
    if (SymbolValid !== 1'b1) $display("[TB] FAIL realign_valid: got %b, required 1", SymbolValid); else passes++;
    if (SymbolOut !== COMMA_N) $display("[TB] FAIL realign_symbol: got %h, required %h", SymbolOut, COMMA_N); else passes++;
    if (AlignErrors !== expErr) $display("[TB] FAIL unlock_errors: got %0d, required %0d", AlignErrors, expErr); else passes++;
    for (int i = 1; i < 10; i++) sendBit(sym[i]);
    sendSymbol(sym);
    sendSymbol(sym);
    checks++;
    if (Locked !== 1'b0) $display("[TB] FAIL relock_early: got %b, required 0", Locked); else passes++;
    sendSymbol(DATA_SYM);
    checks++;
    if (Locked !== 1'b1) $display("[TB] FAIL relock_shifted: got %b, required 1", Locked); else passes++;
    drain();
    checks++;
    if (expectQ.size() != 0) $display("[TB] FAIL unlock_pending: got %0d, required 0", expectQ.size()); else passes++;
  endtask

  task automatic test_partial_misalign();
    logic [9:0]  filler;
    logic [15:0] expErr;
    bit          dropped;
`ifdef ALIGN_ERR_COUNT_EN
    expErr = 16'd10;
`else
    expErr = 16'd0;
`endif
    filler  = DATA_SYM;
    dropped = 1'b0;
    acquireLock();
    for (int r = 0; r < 5; r++) begin
      sendBit(1'b0);
      sendSymbol(COMMA_N);
      sendSymbol(COMMA_N);
      for (int i = 0; i < 9; i++) sendBit(filler[i]);
      sendSymbol(COMMA_N);
      if (Locked !== 1'b1) dropped = 1'b1;
    end
    drain();
    checks += 3;
    if (dropped !== 1'b0) $display("[TB] FAIL partial_lock_held: got drop=%b, required 0", dropped); else passes++;
    if (AlignErrors !== expErr) $display("[TB] FAIL partial_errors: got %0d, required %0d", AlignErrors, expErr); else passes++;
    if (expectQ.size() != 0) $display("[TB] FAIL partial_pending: got %0d, required 0", expectQ.size()); else passes++;
  endtask

  task automatic test_stable_and_reset();
    logic [9:0] sym;
    logic [9:0] exp;
    sym = DATA_SYM;
    acquireLock();
    sendSymbol(sym);
    for (int i = 0; i < 4; i++) sendBit(sym[i]);
    Stable = 1'b0;
    sendBit(sym[4]);
    Stable    = 1'b1;
    trackEmit = 1'b0;
    checks += 3;
    if (Locked !== 1'b0) $display("[TB] FAIL stable_locked: got %b, required 0", Locked); else passes++;
    if (SymbolValid !== 1'b0) $display("[TB] FAIL stable_valid: got %b, required 0", SymbolValid); else passes++;
    if (SymbolOut !== DATA_SYM) $display("[TB] FAIL stable_hold: got %h, required %h", SymbolOut, DATA_SYM); else passes++;
    for (int i = 5; i < 10; i++) sendBit(sym[i]);
    sendSymbol(COMMA_N);
    bitCnt    = 9;
    trackEmit = 1'b1;
    sendSymbol(COMMA_N);
    sendSymbol(COMMA_N);
    sendSymbol(COMMA_N);
    checks++;
    if (Locked !== 1'b0) $display("[TB] FAIL stable_relock_early: got %b, required 0", Locked); else passes++;
    sendSymbol(sym);
    checks++;
    if (Locked !== 1'b1) $display("[TB] FAIL stable_relock: got %b, required 1", Locked); else passes++;
    sendBit(sym[0]);
    exp = expectQ.pop_front();
    checks += 2;
    if (SymbolValid !== 1'b1) $display("[TB] FAIL premreset_valid: got %b, required 1", SymbolValid); else passes++;
    if (SymbolOut !== exp) $display("[TB] FAIL premreset_symbol: got %h, required %h", SymbolOut, exp); else passes++;
    Reset = 1'b1;
    #1;
    checks += 5;
    if (SymbolOut !== 10'h000) $display("[TB] FAIL midreset_symbol: got %h, required 000", SymbolOut); else passes++;
    if (SymbolValid !== 1'b0) $display("[TB] FAIL midreset_valid: got %b, required 0", SymbolValid); else passes++;
    if (Locked !== 1'b0) $display("[TB] FAIL midreset_locked: got %b, required 0", Locked); else passes++;
    if (AlignErrors !== 16'h0000) $display("[TB] FAIL midreset_errors: got %h, required 0000", AlignErrors); else passes++;
    if (expectQ.size() != 0) $display("[TB] FAIL stable_pending: got %0d, required 0", expectQ.size()); else passes++;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_data_stream();
    test_unlock();
    test_partial_misalign();
    test_stable_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
